// File: rtl/eu_muldiv_way1_if.sv
// Operand/decode bundle from the way1 EU register stage plus the result bundle
// toward writeback, grouped for the iterative multiply/divide unit.
interface eu_muldiv_way1_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic            ready_o;
    logic [6:0]      opCode_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [XLEN-1:0] rs1ReadData_i;
    logic [XLEN-1:0] rs2ReadData_i;
    logic [4:0]      rdAddr_i;
    logic            rdWriteEnable_i;
    logic [31:0]     instAddr_i;
    logic [1:0]      way1_pID_i;
    logic            jumpFlag_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rdAddr_o;
    logic            rdWriteEnable_o;
    logic [31:0]     instAddr_o;
    logic [1:0]      way1_pID_o;

    modport slave (
        input  valid_i, opCode_i, funct3_i, funct7_i, rs1ReadData_i, rs2ReadData_i,
               rdAddr_i, rdWriteEnable_i, instAddr_i, way1_pID_i, jumpFlag_i, ready_i,
        output ready_o, valid_o, result_o, rdAddr_o, rdWriteEnable_o, instAddr_o, way1_pID_o
    );

    modport master (
        output valid_i, opCode_i, funct3_i, funct7_i, rs1ReadData_i, rs2ReadData_i,
               rdAddr_i, rdWriteEnable_i, instAddr_i, way1_pID_i, jumpFlag_i, ready_i,
        input  ready_o, valid_o, result_o, rdAddr_o, rdWriteEnable_o, instAddr_o, way1_pID_o
    );
endinterface

// File: rtl/eu_muldiv_way1.sv
// Iterative RV64M multiply/divide unit for way1: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, result held until writeback takes it.
module eu_muldiv_way1 #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    eu_muldiv_way1_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rdAddr;
    logic                r_rdWriteEnable;
    logic [31:0]         r_instAddr;
    logic [1:0]          r_pID;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_isW;
    logic                r_isRem;
    logic                r_hiSel;
    logic                r_negQ;
    logic                r_negR;
    logic                r_special;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_opA;
    logic [XLEN-1:0]     r_opB;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quot;

    logic [2:0]          w_f3;
    logic                w_isW;
    logic                w_isMD;
    logic                w_accept;
    logic                w_isMul;
    logic                w_isRem;
    logic                w_sgnA;
    logic                w_sgnB;
    logic [XLEN-1:0]     w_opA;
    logic [XLEN-1:0]     w_opB;
    logic                w_negA;
    logic                w_negB;
    logic [XLEN-1:0]     w_magA;
    logic [XLEN-1:0]     w_magB;
    logic                w_divZero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_specVal;
    logic [XLEN-1:0]     w_specRes;
    logic                w_last;
    logic [2*XLEN-1:0]   w_prodNext;
    logic [2*XLEN-1:0]   w_prodFix;
    logic [XLEN-1:0]     w_mulRes;
    logic [XLEN:0]       w_diff;
    logic                w_qBit;
    logic [XLEN-1:0]     w_remNext;
    logic [XLEN-1:0]     w_quotNext;
    logic [XLEN-1:0]     w_divRaw;
    logic [XLEN-1:0]     w_divRes;

    assign w_f3     = bus.funct3_i;
    assign w_isW    = (bus.opCode_i == OPC_OP32);
    assign w_isMD   = bus.valid_i & (bus.funct7_i == 7'b0000001) &
                      ((bus.opCode_i == OPC_OP) | (w_isW & ((w_f3 == 3'd0) | w_f3[2])));
    assign w_accept = w_isMD & (r_state == IDLE) & ~bus.jumpFlag_i;
    assign w_isMul  = ~w_f3[2];
    assign w_isRem  = w_f3[1];
    assign w_sgnA   = (w_f3 == 3'd1) | (w_f3 == 3'd2) | (w_f3 == 3'd4) | (w_f3 == 3'd6);
    assign w_sgnB   = (w_f3 == 3'd1) | (w_f3 == 3'd4) | (w_f3 == 3'd6);

    // W ops work on the low word, extended according to the operand's signedness.
    assign w_opA  = w_isW ? {{(XLEN-32){w_sgnA & bus.rs1ReadData_i[31]}}, bus.rs1ReadData_i[31:0]}
                          : bus.rs1ReadData_i;
    assign w_opB  = w_isW ? {{(XLEN-32){w_sgnB & bus.rs2ReadData_i[31]}}, bus.rs2ReadData_i[31:0]}
                          : bus.rs2ReadData_i;
    assign w_negA = w_sgnA & w_opA[XLEN-1];
    assign w_negB = w_sgnB & w_opB[XLEN-1];
    assign w_magA = w_negA ? ({XLEN{1'b0}} - w_opA) : w_opA;
    assign w_magB = w_negB ? ({XLEN{1'b0}} - w_opB) : w_opB;

    assign w_divZero = (w_opB == {XLEN{1'b0}});
    assign w_ovf     = w_sgnA & w_sgnB & (&w_opB) &
                       (w_opA == (w_isW ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
    assign w_special = ~w_isMul & (w_divZero | w_ovf);
    assign w_specVal = w_divZero ? (w_isRem ? w_opA : {XLEN{1'b1}})
                                 : (w_isRem ? {XLEN{1'b0}} : w_opA);
    assign w_specRes = w_isW ? sext32(w_specVal[31:0]) : w_specVal;

    assign w_last = (r_cnt == (r_isW ? CNT_W'(31) : CNT_W'(XLEN-1)));

    assign w_prodNext = r_acc + (r_opA[0] ? r_mcand : {(2*XLEN){1'b0}});
    assign w_prodFix  = r_negQ ? ({(2*XLEN){1'b0}} - w_prodNext) : w_prodNext;
    assign w_mulRes   = r_hiSel ? w_prodFix[2*XLEN-1:XLEN]
                                : (r_isW ? sext32(w_prodFix[31:0]) : w_prodFix[XLEN-1:0]);

    // Restoring step: the borrow out of the trial subtraction is the inverted quotient bit.
    assign w_diff     = {r_rem, r_opA[XLEN-1]} - {1'b0, r_opB};
    assign w_qBit     = ~w_diff[XLEN];
    assign w_remNext  = w_qBit ? w_diff[XLEN-1:0] : {r_rem[XLEN-2:0], r_opA[XLEN-1]};
    assign w_quotNext = {r_quot[XLEN-2:0], w_qBit};
    assign w_divRaw   = r_isRem ? (r_negR ? ({XLEN{1'b0}} - w_remNext) : w_remNext)
                                : (r_negQ ? ({XLEN{1'b0}} - w_quotNext) : w_quotNext);
    assign w_divRes   = r_isW ? sext32(w_divRaw[31:0]) : w_divRaw;

    // Control FSM and datapath registers; a flush in any busy state drops the operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_ready         <= 1'b1;
            r_valid         <= 1'b0;
            r_result        <= '0;
            r_rdAddr        <= '0;
            r_rdWriteEnable <= 1'b0;
            r_instAddr      <= '0;
            r_pID           <= '0;
            r_cnt           <= '0;
            r_isW           <= 1'b0;
            r_isRem         <= 1'b0;
            r_hiSel         <= 1'b0;
            r_negQ          <= 1'b0;
            r_negR          <= 1'b0;
            r_special       <= 1'b0;
            r_acc           <= '0;
            r_mcand         <= '0;
            r_opA           <= '0;
            r_opB           <= '0;
            r_rem           <= '0;
            r_quot          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rdAddr        <= bus.rdAddr_i;
                        r_rdWriteEnable <= bus.rdWriteEnable_i;
                        r_instAddr      <= bus.instAddr_i;
                        r_pID           <= bus.way1_pID_i;
                        r_cnt           <= '0;
                        r_isW           <= w_isW;
                        r_isRem         <= w_isRem;
                        r_hiSel         <= w_isMul & (w_f3 != 3'd0);
                        r_negQ          <= w_negA ^ w_negB;
                        r_negR          <= w_negA;
                        r_special       <= w_special;
                        r_ready         <= 1'b0;
                        r_acc           <= '0;
                        r_rem           <= '0;
                        r_mcand         <= {{XLEN{1'b0}}, w_magA};
                        r_opB           <= w_magB;
                        if (w_isMul) begin
                            r_opA   <= w_magB;
                            r_quot  <= '0;
                            r_state <= MUL;
                        end else begin
                            r_opA   <= w_isW ? {w_magA[31:0], {(XLEN-32){1'b0}}} : w_magA;
                            r_quot  <= w_special ? w_specRes : {XLEN{1'b0}};
                            r_state <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (bus.jumpFlag_i) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (w_last) begin
                        r_result <= w_mulRes;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_acc   <= w_prodNext;
                        r_mcand <= {r_mcand[2*XLEN-2:0], 1'b0};
                        r_opA   <= {1'b0, r_opA[XLEN-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (bus.jumpFlag_i) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (r_special) begin
                        r_result <= r_quot;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_last) begin
                        r_result <= w_divRes;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_rem  <= w_remNext;
                        r_quot <= w_quotNext;
                        r_opA  <= {r_opA[XLEN-2:0], 1'b0};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.jumpFlag_i || bus.ready_i) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o         = r_ready;
    assign bus.valid_o         = r_valid;
    assign bus.result_o        = r_result;
    assign bus.rdAddr_o        = r_rdAddr;
    assign bus.rdWriteEnable_o = r_rdWriteEnable;
    assign bus.instAddr_o      = r_instAddr;
    assign bus.way1_pID_o      = r_pID;
endmodule
